addsub_pipe: RTL and testbench
==============================

// Module: addsub_pipe
// PURPOSE
//  Parametrised, pipelined two-operand adder/subtractor with a per-transaction ADD/SUB select,
//  a signed/unsigned build mode, an exact (WIDTH+1)-bit result and an overflow flag.
//  The carry chain is split across STAGES register stages. It accepts one operation per cycle
//  with full STB/ACK backpressure. Drop-in successor to the single-cycle adder in the datapath.
// PARAMETERS
//  WIDTH   32  operand width in bits, >= 2
//  STAGES  4   pipeline/carry-chunk count, 1 <= STAGES <= WIDTH; latency in cycles
//  SIGNED  0   0: operands unsigned (zero-extend); 1: operands two's complement (sign-extend)
// PORTS
//  CLK      in   1        clock, all state on rising edge
//  RST      in   1        asynchronous, active-low reset
//  I_STB    in   1        input operation valid
//  I_ACK    out  1        input accepted this cycle (transfer when I_STB & I_ACK)
//  I_DAT_A  in   WIDTH    operand A
//  I_DAT_B  in   WIDTH    operand B
//  I_SUB    in   1        0: A+B, 1: A-B; sampled with the operands
//  O_STB    out  1        result valid
//  O_DAT    out  WIDTH+1  exact result, two's complement in WIDTH+1 bits
//  O_OVF    out  1        result does not fit in WIDTH bits of the selected mode
//  O_ACK    in   1        consumer accepts result (transfer when O_STB & O_ACK)
// BEHAVIOUR
//  - Reset (RST low): all stage valid bits, O_STB, O_OVF and O_DAT clear to 0 immediately,
//    asynchronously. I_ACK = 0 while RST is low. In-flight operations are discarded, never emitted.
//  - Arithmetic: ext(x) = zero-/sign-extend x to WIDTH+1 per SIGNED.
//    O_DAT = ext(A) + ext(B), or ext(A) + ~ext(B) + 1 when I_SUB=1, i.e. modulo 2^(WIDTH+1);
//    the result is always exact.
//    O_OVF: SIGNED=1 -> O_DAT[WIDTH] != O_DAT[WIDTH-1]; SIGNED=0 -> O_DAT[WIDTH] (carry on add, borrow on sub).
//  - Carry split: CW = ceil(WIDTH/STAGES). Stage k adds operand bits [k*CW +: CW] plus the registered
//    carry from stage k-1; the top chunk is ragged and also handles the extension bit.
//    Unprocessed operand bits and finished low result bits ride along in pipeline registers.
//    No combinational carry path spans more than one chunk.
//  - Pipeline: valid bit v[k] per stage; stage k ready r[k] = ~v[k] | r[k+1]; r[STAGES] = O_ACK.
//    A stage loads when its upstream is valid and r[k]=1; I_ACK = r[0].
//    O_STB = v[STAGES-1]; O_DAT and O_OVF come from the last stage registers.
//  - Latency: an op accepted at edge n is presented at O_STB after edge n+STAGES-1 when not stalled.
//    STAGES=1 behaves as a single output register.
//  - Throughput: 1 op/cycle with O_ACK held high. I_ACK stays high on a full pipe when O_ACK=1
//    (simultaneous drain and fill).
//  - Stall: O_STB=1 & O_ACK=0 -> O_DAT/O_OVF/O_STB held stable. Pipe fills to STAGES ops, then I_ACK=0.
//    No op is lost, duplicated or reordered.
//  - O_STB never drops without an O_ACK transfer, except on reset. I_STB may drop at any time without effect.
//  - Operand and I_SUB values are don't-care unless I_STB & I_ACK.
// TESTING
//  1. W=32,S=4,SIGNED=0: A=FFFFFFFF,B=1,add, O_ACK=1 -> O_STB 4 edges later, O_DAT=1_00000000, O_OVF=1.
//  2. SIGNED=0: A=5,B=7,sub -> O_DAT=1_FFFFFFFE, O_OVF=1 (borrow); then A=7,B=5,sub -> O_DAT=2, O_OVF=0.
//  3. SIGNED=1: A=7FFFFFFF,B=1,add -> O_DAT=0_80000000, O_OVF=1; A=80000000,B=1,sub -> O_DAT=1_7FFFFFFF, O_OVF=1.
//  4. 1000 random ops, random I_SUB, I_STB and O_ACK held 1 -> one result per cycle, in order,
//     match reference model, I_ACK never low.
//  5. Random I_STB/O_ACK backpressure; hold O_ACK=0 for 10 cycles -> exactly STAGES ops accepted,
//     then I_ACK=0, outputs stable. Release -> all results in order, none lost or duplicated.
//  6. RST low mid-stream with a full pipe -> O_STB, O_DAT, O_OVF = 0 asynchronously and I_ACK=0.
//     After release the first accepted op yields the correct result after STAGES cycles,
//     and no stale result appears.

Source files
------------

// File: rtl/addsub_pipe.sv
// Pipelined add/sub with the carry chain split into STAGES chunks; latency STAGES cycles.
// Backpressure: ready ripples back from O_ACK, so a full pipe still accepts when the output drains.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int SIGNED = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             I_STB,
  output logic             I_ACK,
  input  logic [WIDTH-1:0] I_DAT_A,
  input  logic [WIDTH-1:0] I_DAT_B,
  input  logic             I_SUB,
  output logic             O_STB,
  output logic [WIDTH:0]   O_DAT,
  output logic             O_OVF,
  input  logic             O_ACK
);

  localparam int XW = WIDTH + 1;
  localparam int CW = (WIDTH + STAGES - 1) / STAGES;

  logic [STAGES-1:0] v_q, v_d, rdy, up_vld, load;
  logic [XW-1:0]     a_q [STAGES];
  logic [XW-1:0]     b_q [STAGES];
  logic [XW-1:0]     res_q [STAGES];
  logic              cy_q [STAGES];
  logic [XW-1:0]     a_d [STAGES];
  logic [XW-1:0]     b_d [STAGES];
  logic [XW-1:0]     r_in [STAGES];
  logic              c_in [STAGES];
  logic [XW-1:0]     res_d [STAGES];
  logic              cy_d [STAGES];
  logic [XW-1:0]     ext_a, ext_b;

  always_comb begin
    ext_a = (SIGNED != 0) ? {I_DAT_A[WIDTH-1], I_DAT_A} : {1'b0, I_DAT_A};
    ext_b = (SIGNED != 0) ? {I_DAT_B[WIDTH-1], I_DAT_B} : {1'b0, I_DAT_B};
  end

  // Stage 0 takes the extended operands (B pre-inverted for subtract, carry-in = I_SUB);
  // later stages take operands, partial result and carry from the previous register.
  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_first
      assign a_d[k]    = ext_a;
      assign b_d[k]    = I_SUB ? ~ext_b : ext_b;
      assign r_in[k]   = '0;
      assign c_in[k]   = I_SUB;
      assign up_vld[k] = I_STB;
    end else begin : g_next
      assign a_d[k]    = a_q[k-1];
      assign b_d[k]    = b_q[k-1];
      assign r_in[k]   = res_q[k-1];
      assign c_in[k]   = cy_q[k-1];
      assign up_vld[k] = v_q[k-1];
    end
  end

  always_comb begin
    logic r;
    r   = O_ACK;
    rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = ~v_q[k] | r;
      rdy[k] = r;
    end
  end

  always_comb begin
    load = '0;
    v_d  = '0;
    for (int k = 0; k < STAGES; k++) begin
      load[k] = up_vld[k] & rdy[k];
      v_d[k]  = rdy[k] ? up_vld[k] : v_q[k];
    end
  end

  // Each stage ripples only its own chunk; the top chunk is clamped to include the extension bit.
  always_comb begin
    logic c;
    int   lo;
    int   hi;
    c  = 1'b0;
    lo = 0;
    hi = 0;
    for (int k = 0; k < STAGES; k++) begin
      lo = k * CW;
      hi = (k == STAGES - 1) ? WIDTH : (k + 1) * CW - 1;
      if (hi > WIDTH) hi = WIDTH;
      c        = c_in[k];
      res_d[k] = r_in[k];
      for (int i = 0; i < XW; i++) begin
        if (i >= lo && i <= hi) begin
          res_d[k][i] = a_d[k][i] ^ b_d[k][i] ^ c;
          c           = (a_d[k][i] & b_d[k][i]) | (c & (a_d[k][i] ^ b_d[k][i]));
        end
      end
      cy_d[k] = c;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
        cy_q[k]  <= 1'b0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          res_q[k] <= res_d[k];
          cy_q[k]  <= cy_d[k];
        end
      end
    end
  end

  assign I_ACK = rdy[0] & RST;
  assign O_STB = v_q[STAGES-1];
  assign O_DAT = res_q[STAGES-1];
  assign O_OVF = (SIGNED != 0) ? (O_DAT[WIDTH] ^ O_DAT[WIDTH-1]) : O_DAT[WIDTH];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: an unsigned 4-stage and a signed 3-stage instance, scoreboard checked.
module tb_addsub_pipe;
  localparam int W  = 32;
  localparam int S0 = 4;
  localparam int S1 = 3;

  typedef struct packed {
    logic [W:0] dat;
    logic       ovf;
  } exp_t;

  typedef struct {
    int         d;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic       s;
    logic [W:0] dat;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stb [2];
  logic       sub [2];
  logic       o_ack [2];
  logic       i_ack [2];
  logic       o_stb [2];
  logic       o_ovf [2];
  logic [W-1:0] da [2];
  logic [W-1:0] db [2];
  logic [W:0] o_dat [2];
  exp_t       drv_exp [2];
  exp_t       q0 [$];
  exp_t       q1 [$];
  exp_t       held [2];
  bit         hold_v [2];
  bit         rand_ack [2];
  int         checks = 0;
  int         errors = 0;
  vec_t       tbl [15];

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(W), .STAGES(S0), .SIGNED(0)) u_uns (
    .CLK(clk), .RST(rst_n), .I_STB(stb[0]), .I_ACK(i_ack[0]), .I_DAT_A(da[0]), .I_DAT_B(db[0]),
    .I_SUB(sub[0]), .O_STB(o_stb[0]), .O_DAT(o_dat[0]), .O_OVF(o_ovf[0]), .O_ACK(o_ack[0]));

  addsub_pipe #(.WIDTH(W), .STAGES(S1), .SIGNED(1)) u_sgn (
    .CLK(clk), .RST(rst_n), .I_STB(stb[1]), .I_ACK(i_ack[1]), .I_DAT_A(da[1]), .I_DAT_B(db[1]),
    .I_SUB(sub[1]), .O_STB(o_stb[1]), .O_DAT(o_dat[1]), .O_OVF(o_ovf[1]), .O_ACK(o_ack[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsz(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t mdl(input int d, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint ea, eb, r;
    exp_t   e;
    if (d == 1) begin
      ea = longint'($signed(a));
      eb = longint'($signed(b));
    end else begin
      ea = longint'({32'h0, a});
      eb = longint'({32'h0, b});
    end
    r     = s ? ea - eb : ea + eb;
    e.dat = r[W:0];
    if (d == 1) e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    else        e.ovf = (r < 0) || (r > 64'sd4294967295);
    return e;
  endfunction

  // Scoreboard: push on accepted input, pop on output transfer, and check held outputs under stall.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      hold_v[0] = 1'b0;
      hold_v[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (hold_v[d]) begin
          chk($sformatf("hold_stb%0d", d), 64'(o_stb[d]), 64'd1);
          chk($sformatf("hold_dat%0d", d), 64'({o_dat[d], o_ovf[d]}), 64'(held[d]));
        end
        if (stb[d] && i_ack[d]) begin
          if (d == 0) q0.push_back(drv_exp[d]);
          else        q1.push_back(drv_exp[d]);
        end
        if (o_stb[d] && o_ack[d]) begin
          if (qsz(d) == 0) begin
            checks++;
            errors++;
            $display("FAIL stale_output dut%0d: got %h with nothing outstanding", d, {o_dat[d], o_ovf[d]});
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("result%0d", d), 64'({o_dat[d], o_ovf[d]}), 64'(e));
          end
        end
        hold_v[d] = o_stb[d] && !o_ack[d];
        held[d]   = {o_dat[d], o_ovf[d]};
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) if (rand_ack[d]) o_ack[d] = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input exp_t e, output int waits);
    bit acc;
    bit done;
    stb[d] = 1'b1; da[d] = a; db[d] = b; sub[d] = s; drv_exp[d] = e;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      acc = i_ack[d];
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
      else     waits++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d: got no I_ACK expected acceptance within 200 cycles", d);
    end
    stb[d] = 1'b0;
  endtask

  task automatic send_rand(input int d, output int waits);
    logic [W-1:0] a, b;
    logic s;
    a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
    send(d, a, b, s, mdl(d, a, b, s), waits);
  endtask

  task automatic drain(input int d);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (qsz(d) == 0 && !o_stb[d]) done = 1'b1;
      else step();
    end
    chk($sformatf("drain%0d", d), 64'(done), 64'd1);
  endtask

  task automatic lat_check(input int d, input int st);
    chk($sformatf("latency_early%0d", d), 64'(o_stb[d]), 64'd0);
    for (int i = 1; i < st; i++) begin
      step();
      chk($sformatf("latency%0d_%0d", d, i), 64'(o_stb[d]), 64'(i == st - 1));
    end
  endtask

  // Holds O_ACK low while offering a new op every cycle; returns the number accepted.
  task automatic stall_offer(input int d, input int cycles, output int cnt);
    bit acc;
    logic [W-1:0] a, b;
    logic s;
    o_ack[d] = 1'b0;
    cnt = 0;
    a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
    stb[d] = 1'b1; da[d] = a; db[d] = b; sub[d] = s; drv_exp[d] = mdl(d, a, b, s);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      acc = i_ack[d];
      if (acc) cnt++;
      @(posedge clk);
      #1;
      if (acc) begin
        a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
        da[d] = a; db[d] = b; sub[d] = s; drv_exp[d] = mdl(d, a, b, s);
      end
    end
    stb[d] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   w;
    int   cnt;
    exp_t e;

    tbl[0]  = '{0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h1_0000_0000, 1'b1};
    tbl[1]  = '{0, 32'h00000005, 32'h00000007, 1'b1, 33'h1_FFFF_FFFE, 1'b1};
    tbl[2]  = '{0, 32'h00000007, 32'h00000005, 1'b1, 33'h0_0000_0002, 1'b0};
    tbl[3]  = '{0, 32'h00000000, 32'h00000000, 1'b1, 33'h0_0000_0000, 1'b0};
    tbl[4]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33'h1_FFFF_FFFE, 1'b1};
    tbl[5]  = '{0, 32'h000000FF, 32'h00000001, 1'b0, 33'h0_0000_0100, 1'b0};
    tbl[6]  = '{0, 32'h00FFFFFF, 32'h00000001, 1'b0, 33'h0_0100_0000, 1'b0};
    tbl[7]  = '{0, 32'h80000000, 32'h00000001, 1'b1, 33'h0_7FFF_FFFF, 1'b0};
    tbl[8]  = '{1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 33'h0_8000_0000, 1'b1};
    tbl[9]  = '{1, 32'h80000000, 32'h00000001, 1'b1, 33'h1_7FFF_FFFF, 1'b1};
    tbl[10] = '{1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h0_0000_0000, 1'b0};
    tbl[11] = '{1, 32'h80000000, 32'h80000000, 1'b0, 33'h1_0000_0000, 1'b1};
    tbl[12] = '{1, 32'h00000000, 32'h80000000, 1'b1, 33'h0_8000_0000, 1'b1};
    tbl[13] = '{1, 32'h00000005, 32'h00000007, 1'b1, 33'h1_FFFF_FFFE, 1'b0};
    tbl[14] = '{1, 32'h000007FF, 32'h00000001, 1'b0, 33'h0_0000_0800, 1'b0};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      stb[d] = 1'b0; sub[d] = 1'b0; da[d] = '0; db[d] = '0;
      o_ack[d] = 1'b1; rand_ack[d] = 1'b0; drv_exp[d] = '0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ostb%0d", d), 64'(o_stb[d]), 64'd0);
      chk($sformatf("reset_iack%0d", d), 64'(i_ack[d]), 64'd0);
      chk($sformatf("reset_odat%0d", d), 64'({o_dat[d], o_ovf[d]}), 64'd0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Single-op latency on each instance, using spec corner values.
    e = '{dat: tbl[0].dat, ovf: tbl[0].ovf};
    send(0, tbl[0].a, tbl[0].b, tbl[0].s, e, w);
    lat_check(0, S0);
    drain(0);
    e = '{dat: tbl[8].dat, ovf: tbl[8].ovf};
    send(1, tbl[8].a, tbl[8].b, tbl[8].s, e, w);
    lat_check(1, S1);
    drain(1);

    for (int i = 0; i < 15; i++) begin
      e = '{dat: tbl[i].dat, ovf: tbl[i].ovf};
      send(tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].s, e, w);
    end
    drain(0);
    drain(1);

    // Full throughput: I_ACK must never be low with O_ACK held high.
    for (int i = 0; i < 1000; i++) begin
      send_rand(0, w);
      chk("throughput_waits0", 64'(w), 64'd0);
    end
    for (int i = 0; i < 300; i++) begin
      send_rand(1, w);
      chk("throughput_waits1", 64'(w), 64'd0);
    end
    drain(0);
    drain(1);

    // Random backpressure with random input gaps.
    rand_ack[0] = 1'b1;
    rand_ack[1] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_rand(i % 2, w);
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_ack[0] = 1'b0;
    rand_ack[1] = 1'b0;
    step();
    o_ack[0] = 1'b1;
    o_ack[1] = 1'b1;
    drain(0);
    drain(1);

    // Long stall: exactly STAGES ops fit, then I_ACK drops until release.
    stall_offer(0, 10, cnt);
    chk("stall_accepted0", 64'(cnt), 64'(S0));
    chk("stall_iack0", 64'(i_ack[0]), 64'd0);
    o_ack[0] = 1'b1;
    drain(0);
    stall_offer(1, 10, cnt);
    chk("stall_accepted1", 64'(cnt), 64'(S1));
    chk("stall_iack1", 64'(i_ack[1]), 64'd0);
    o_ack[1] = 1'b1;
    drain(1);

    // Reset with a full, stalled pipe: outputs clear at once and nothing stale follows.
    stall_offer(0, 6, cnt);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ostb", 64'(o_stb[0]), 64'd0);
    chk("rst_odat", 64'(o_dat[0]), 64'd0);
    chk("rst_oovf", 64'(o_ovf[0]), 64'd0);
    chk("rst_iack", 64'(i_ack[0]), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    o_ack[0] = 1'b1;
    step();
    chk("post_rst_iack", 64'(i_ack[0]), 64'd1);
    chk("post_rst_ostb", 64'(o_stb[0]), 64'd0);
    e = '{dat: tbl[2].dat, ovf: tbl[2].ovf};
    send(0, tbl[2].a, tbl[2].b, tbl[2].s, e, w);
    lat_check(0, S0);
    drain(0);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
